// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer.
// One operation is accepted at a time. Multiplies use radix-2 shift-add and
// divides use restoring division, one bit per cycle. Divide-by-zero and
// signed overflow finish in a single cycle.
module muldiv_seq #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Conditional two's complement negation of one operand/result word.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                              input logic            s);
    return s ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  // Conditional negation of the full double-width product.
  function automatic logic [2*WIDTH-1:0] neg_wide_if(input logic [2*WIDTH-1:0] v,
                                                     input logic              s);
    return s ? ({(2*WIDTH){1'b0}} - v) : v;
  endfunction

  // Sign fix and half/quotient/remainder selection of the final value.
  // For multiplies the whole product is negated before picking a half so
  // the borrow out of the low half reaches the high half correctly.
  function automatic logic [WIDTH-1:0] final_result(input logic [2:0]         f,
                                                    input logic               neg,
                                                    input logic [2*WIDTH-1:0] prod,
                                                    input logic [WIDTH-1:0]   rem);
    logic [2*WIDTH-1:0] p;
    p = neg_wide_if(prod, neg);
    if (f[2]) begin
      return f[1] ? neg_if(rem, neg) : neg_if(prod[WIDTH-1:0], neg);
    end
    return (f[1:0] == 2'b00) ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH];
  endfunction

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic               last_iter;
  logic [CNT_W-1:0]   cnt;

  // Operation context captured at accept
  logic [2:0]         op_q;
  logic               neg_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   rem_q;

  // Accept-side decode
  logic               in_div;
  logic               a_signed;
  logic               b_signed;
  logic               a_neg;
  logic               b_neg;
  logic               div_zero;
  logic               div_ovf;
  logic               special;
  logic               neg_in;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   special_res;

  // Iteration datapath
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_nxt;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   calc_res;

  // Decode the incoming request: operand signedness, magnitudes, short cases
  always_comb begin
    in_div      = op[2];
    a_signed    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg       = a_signed & rs1[WIDTH-1];
    b_neg       = b_signed & rs2[WIDTH-1];
    a_mag       = neg_if(rs1, a_neg);
    b_mag       = neg_if(rs2, b_neg);
    div_zero    = in_div && (rs2 == {WIDTH{1'b0}});
    div_ovf     = in_div && !op[0] && (rs1 == MIN_NEG) && (rs2 == {WIDTH{1'b1}});
    special     = div_zero || div_ovf;
    // Remainder follows the dividend; everything else follows the sign product
    neg_in      = (in_div && op[1]) ? a_neg : (a_neg ^ b_neg);
    special_res = {WIDTH{1'b0}};
    if (div_zero) begin
      special_res = op[1] ? rs1 : {WIDTH{1'b1}};
    end else begin
      special_res = op[1] ? {WIDTH{1'b0}} : MIN_NEG;
    end
  end

  // One shift-add or restoring-divide step from the current registers
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    div_ge    = !div_trial[WIDTH];
    rem_nxt   = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    if (op_q[2]) begin
      acc_nxt = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
    end else begin
      acc_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    end
    last_iter = (cnt == CNT_W'(WIDTH-1));
    calc_res  = final_result(op_q, neg_q, acc_nxt, rem_nxt);
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (in_valid && !flush) begin
          accept    = 1'b1;
          state_nxt = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A flush overrides everything, including a pending out_ready handshake
    if (flush) begin
      state_nxt = IDLE;
    end
  end

  // Control state, iteration counter and the visible result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= '0;
      end else if ((state == CALC) && !flush && !last_iter) begin
        cnt <= cnt + 1'b1;
      end
      if (accept && special) begin
        result <= special_res;
      end else if ((state == CALC) && last_iter && !flush) begin
        result <= calc_res;
      end
    end
  end

  // Operand context and working registers (no reset: only read in CALC)
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= op;
      neg_q  <= neg_in;
      opnd_q <= in_div ? b_mag : a_mag;
      acc_q  <= in_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
      rem_q  <= '0;
    end else if (state == CALC) begin
      acc_q  <= acc_nxt;
      rem_q  <= rem_nxt;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: vector table, random vectors against a
// reference model, and hand-written handshake/flush/reset sequences.
module tb_muldiv_seq;

  localparam int W   = 32;
  localparam int LAT = W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] rs1;
  logic [W-1:0] rs2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  muldiv_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour from plain wide arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] ub;
    logic signed [63:0] p;
    logic [63:0]        up;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && ((b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 0;
    return LAT;
  endfunction

  // Wait for in_ready, present one request for exactly one cycle, push expectation
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", {63'b0, in_ready}, 64'd1);
    op       = o;
    rs1      = a;
    rs2      = b;
    in_valid = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op       = 3'($urandom);
    rs1      = $urandom;
    rs2      = $urandom;
  endtask

  // Wait for out_valid, check latency and result against the scoreboard, handshake
  task automatic collect(input string name, input int lat);
    int n;
    logic [31:0] exp;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_lat"}, 64'(n), 64'(lat));
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      exp = sb_q.pop_front();
      chk({name, "_res"}, {32'b0, result}, {32'b0, exp});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_idle"}, {62'b0, out_valid, in_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int seen;
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] junk;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, LAT};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, LAT};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, LAT};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,          32'd14,         LAT};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,          32'd2,          LAT};
    vecs[8]  = '{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF, 0};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,          32'd5,          0};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          0};
    vecs[12] = '{3'd4, 32'd9,          32'd0,          32'hFFFF_FFFF, 0};
    vecs[13] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          LAT};
    vecs[14] = '{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT};
    vecs[15] = '{3'd1, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, LAT};

    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; rs1 = '0; rs2 = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_result",    {32'b0, result},    64'd0);
    chk("rst_busy",      {63'b0, busy},      64'd0);
    chk("rst_in_ready",  {63'b0, in_ready},  64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      collect($sformatf("vec%0d", i), vecs[i].lat);
    end

    // Random operations against the reference model
    for (int i = 0; i < 10; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      issue(ro, ra, rb, ref_model(ro, ra, rb));
      collect($sformatf("rnd%0d", i), exp_lat(ro, ra, rb));
    end

    // Backpressure: result held with out_ready low, then back-to-back accept
    issue(3'd5, 32'd100, 32'd7, 32'd14);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_lat", 64'(n), 64'(LAT));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_result", {32'b0, result}, 64'd14);
      chk("bp_hold_valid",  {63'b0, out_valid}, 64'd1);
      chk("bp_hold_ready",  {63'b0, in_ready},  64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    junk = sb_q.pop_front();
    chk("bp_idle_ready", {63'b0, in_ready}, 64'd1);
    issue(3'd0, 32'd3, 32'd4, 32'd12);
    collect("bp_next_mul", LAT);

    // Flush in the middle of CALC: no result ever appears
    issue(3'd0, 32'd11, 32'd13, 32'd143);
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    junk = sb_q.pop_front();
    chk("flush_calc_busy",  {63'b0, busy},      64'd0);
    chk("flush_calc_ready", {63'b0, in_ready},  64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("flush_calc_no_out", 64'(seen), 64'd0);
    issue(3'd0, 32'd3, 32'd4, 32'd12);
    collect("flush_then_mul", LAT);

    // Flush beats out_ready in DONE
    issue(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
    chk("flush_done_valid", {63'b0, out_valid}, 64'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    junk = sb_q.pop_front();
    chk("flush_done_gone", {62'b0, out_valid, in_ready}, 64'd1);

    // Flush together with in_valid: nothing is accepted
    op = 3'd0; rs1 = 32'd2; rs2 = 32'd2; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_no_accept", {63'b0, busy}, 64'd0);

    // Asynchronous reset in the middle of CALC
    issue(3'd0, 32'd5, 32'd6, 32'd30);
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_busy", {63'b0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    junk = sb_q.pop_front();
    chk("mid_rst_valid",  {63'b0, out_valid}, 64'd0);
    chk("mid_rst_result", {32'b0, result},    64'd0);
    chk("mid_rst_busy",   {63'b0, busy},      64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(3'd0, 32'd5, 32'd6, 32'd30);
    collect("post_rst_mul", LAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
